hit_merge_fifo: RTL and testbench

- Sits directly upstream of the z-buffer stage, at the rasterizer's hit-test output.
- Collects the two parallel hit lanes (R18 and R19) and buffers them in a 2-write/1-read FIFO.
- Emits one hit per cycle on a valid/ready stream to the z-buffer/fragment writer.
- Throttles the rasterizer pipeline with an active-low halt when the buffer nears full.

---
 rtl/hit_merge_fifo_pkg.sv | 18 +
 rtl/hit_merge_fifo_if.sv | 32 +++
 rtl/hit_merge_fifo_mem.sv | 27 ++
 rtl/hit_merge_fifo.sv | 81 ++++++++
 tb/tb_hit_merge_fifo.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hit_merge_fifo_pkg.sv
// Shared raster hit types: field widths and the packed FIFO entry carried
// from the hit-test lanes to the z-buffer stage.
package raster_hit_pkg;
  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  typedef logic signed [SIGFIG-1:0] sfig_t;
  typedef logic        [SIGFIG-1:0] ufig_t;
  typedef sfig_t [AXIS-1:0]   hit_vec_t;
  typedef ufig_t [COLORS-1:0] color_vec_t;

  typedef struct packed {
    hit_vec_t   hit;
    color_vec_t color;
  } hit_entry_t;
endpackage

// File: rtl/hit_merge_fifo_if.sv
// Hit merge stream bundle: two push lanes with halt back-pressure upstream,
// one valid/ready hit stream plus sticky overflow downstream.
interface hit_merge_fifo_if;
  import raster_hit_pkg::*;

  hit_vec_t   hit_R18S;
  color_vec_t color_R18U;
  logic       hit_valid_R18H;
  hit_vec_t   hit_R19S;
  color_vec_t color_R19U;
  logic       hit_valid_R19H;
  logic       halt_RnnnnL;
  hit_vec_t   hit_R20S;
  color_vec_t color_R20U;
  logic       hit_valid_R20H;
  logic       hit_ready_R20H;
  logic       overflow_RnnnnH;

  modport slave (
    input  hit_R18S, color_R18U, hit_valid_R18H,
    input  hit_R19S, color_R19U, hit_valid_R19H,
    input  hit_ready_R20H,
    output halt_RnnnnL, hit_R20S, color_R20U, hit_valid_R20H, overflow_RnnnnH
  );

  modport master (
    output hit_R18S, color_R18U, hit_valid_R18H,
    output hit_R19S, color_R19U, hit_valid_R19H,
    output hit_ready_R20H,
    input  halt_RnnnnL, hit_R20S, color_R20U, hit_valid_R20H, overflow_RnnnnH
  );
endinterface

// File: rtl/hit_merge_fifo_mem.sv
// Hit FIFO storage: two write ports (always distinct addresses) and one
// asynchronous read port; contents are never reset.
module hit_fifo_mem
  import raster_hit_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int DEPTH_L2 = 4
) (
  input  logic                clk,
  input  logic                we0,
  input  logic [DEPTH_L2-1:0] waddr0,
  input  hit_entry_t          wdata0,
  input  logic                we1,
  input  logic [DEPTH_L2-1:0] waddr1,
  input  hit_entry_t          wdata1,
  input  logic [DEPTH_L2-1:0] raddr,
  output hit_entry_t          rdata
);
  hit_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/hit_merge_fifo.sv
// Merges the R18/R19 hit lanes into a show-ahead FIFO feeding the z-buffer,
// halting the rasterizer early enough that a compliant upstream never overflows.
module hit_merge_fifo
  import raster_hit_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int DEPTH_L2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  hit_merge_fifo_if.slave  bus
);
  localparam int CW = DEPTH_L2 + 1;
  localparam int RW = DEPTH_L2 + 2;

  logic [DEPTH_L2-1:0] wr_ptr, rd_ptr, waddr1;
  logic [CW-1:0]       count, count_next;
  logic [RW-1:0]       room;
  logic [1:0]          n_acc;
  logic                vld_p1, halt_p1, ovf_p1;
  logic                pop, acc18, acc19, drop;
  hit_entry_t          lane0, lane1, head;

  assign lane0.hit   = bus.hit_R18S;
  assign lane0.color = bus.color_R18U;
  assign lane1.hit   = bus.hit_R19S;
  assign lane1.color = bus.color_R19U;

  // Room is measured after this cycle's pop, so a full FIFO that is draining
  // still takes one push; R18 claims room before R19.
  always_comb begin
    pop        = vld_p1 & bus.hit_ready_R20H;
    room       = RW'(DEPTH) - RW'(count) + RW'(pop);
    acc18      = bus.hit_valid_R18H & (room != '0);
    acc19      = bus.hit_valid_R19H & (room > RW'(acc18));
    drop       = (bus.hit_valid_R18H & ~acc18) | (bus.hit_valid_R19H & ~acc19);
    n_acc      = {1'b0, acc18} + {1'b0, acc19};
    count_next = count + CW'(n_acc) - CW'(pop);
    waddr1     = wr_ptr + DEPTH_L2'(acc18);
  end

  hit_fifo_mem #(
    .DEPTH    (DEPTH),
    .DEPTH_L2 (DEPTH_L2)
  ) u_mem (
    .clk    (clk),
    .we0    (acc18),
    .waddr0 (wr_ptr),
    .wdata0 (lane0),
    .we1    (acc19),
    .waddr1 (waddr1),
    .wdata1 (lane1),
    .raddr  (rd_ptr),
    .rdata  (head)
  );

  // Stage p1: pointers, occupancy and the registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      vld_p1  <= 1'b0;
      halt_p1 <= 1'b1;
      ovf_p1  <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + DEPTH_L2'(n_acc);
      rd_ptr  <= rd_ptr + DEPTH_L2'(pop);
      count   <= count_next;
      vld_p1  <= (count_next != '0);
      halt_p1 <= (count_next <= CW'(DEPTH - 2));
      ovf_p1  <= ovf_p1 | drop;
    end
  end

  assign bus.hit_valid_R20H  = vld_p1;
  assign bus.halt_RnnnnL     = halt_p1;
  assign bus.overflow_RnnnnH = ovf_p1;
  assign bus.hit_R20S        = head.hit;
  assign bus.color_R20U      = head.color;
endmodule

// File: tb/tb_hit_merge_fifo.sv
// Scenario bench for hit_merge_fifo: a reference occupancy model plus an
// expected-entry queue checked as the head entry is accepted downstream.
module tb_hit_merge_fifo;
  import raster_hit_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hit_merge_fifo_if bus ();

  hit_merge_fifo #(.DEPTH(DEPTH), .DEPTH_L2(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         mcount = 0;
  bit         movf = 1'b0;
  hit_entry_t exp_q[$];
  hit_entry_t last_pop;

  function automatic hit_entry_t mk(input int id);
    hit_entry_t e;
    logic [23:0] u;
    u = 24'(id);
    e.hit[0]   = sfig_t'(u << 10);
    e.hit[1]   = sfig_t'(24'h000000 - u);
    e.hit[2]   = sfig_t'(24'h800000 | (u * 3));
    e.color[0] = ufig_t'(24'hA00000 | u);
    e.color[1] = ufig_t'(24'h5A0000 ^ (u << 4));
    e.color[2] = ufig_t'(~u);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.hit_valid_R18H = 1'b0;
    bus.hit_valid_R19H = 1'b0;
    bus.hit_ready_R20H = 1'b0;
  endtask

  // One clock of stimulus: drive lanes/ready, check status and the popped head,
  // then advance the reference model across the edge.
  task automatic run_cycle(input bit v18, input int id18, input bit v19,
                           input int id19, input bit rdy);
    hit_entry_t e18, e19, got, exp;
    int  room;
    bit  pop, a18, a19;
    e18 = mk(id18);
    e19 = mk(id19);
    bus.hit_valid_R18H = v18;
    bus.hit_R18S       = e18.hit;
    bus.color_R18U     = e18.color;
    bus.hit_valid_R19H = v19;
    bus.hit_R19S       = e19.hit;
    bus.color_R19U     = e19.color;
    bus.hit_ready_R20H = rdy;

    n_cmp++;
    if (bus.hit_valid_R20H !== (mcount != 0)) begin
      n_err++;
      $display("FAIL valid: got %b want %b (count %0d)", bus.hit_valid_R20H, mcount != 0, mcount);
    end
    n_cmp++;
    if (bus.halt_RnnnnL !== (mcount <= DEPTH - 2)) begin
      n_err++;
      $display("FAIL halt: got %b want %b (count %0d)", bus.halt_RnnnnL, mcount <= DEPTH - 2, mcount);
    end
    n_cmp++;
    if (bus.overflow_RnnnnH !== movf) begin
      n_err++;
      $display("FAIL overflow: got %b want %b", bus.overflow_RnnnnH, movf);
    end

    pop = (mcount != 0) && rdy;
    if (pop && bus.hit_valid_R20H === 1'b1) begin
      got.hit   = bus.hit_R20S;
      got.color = bus.color_R20U;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL head_data: got %h want <nothing queued>", got);
      end else begin
        exp = exp_q.pop_front();
        last_pop = exp;
        if (got !== exp) begin
          n_err++;
          $display("FAIL head_data: got %h want %h", got, exp);
        end
      end
    end

    room = DEPTH - mcount + int'(pop);
    a18  = v18 && room >= 1;
    a19  = v19 && room >= (a18 ? 2 : 1);
    if (a18) exp_q.push_back(e18);
    if (a19) exp_q.push_back(e19);
    if ((v18 && !a18) || (v19 && !a19)) movf = 1'b1;
    mcount = mcount + int'(a18) + int'(a19) - int'(pop);
    tick();
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while ((mcount != 0 || exp_q.size() != 0) && guard < 100) begin
      run_cycle(0, 0, 0, 0, 1);
      guard++;
    end
    n_cmp++;
    if (guard >= 100) begin
      n_err++;
      $display("FAIL %s_drain: %0d entries left, want 0", name, mcount);
    end
    run_cycle(0, 0, 0, 0, 1);
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.hit_valid_R20H !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b want 0", bus.hit_valid_R20H);
    end
    n_cmp++;
    if (bus.halt_RnnnnL !== 1'b1) begin
      n_err++; $display("FAIL reset_halt: got %b want 1", bus.halt_RnnnnL);
    end
    n_cmp++;
    if (bus.overflow_RnnnnH !== 1'b0) begin
      n_err++; $display("FAIL reset_overflow: got %b want 0", bus.overflow_RnnnnH);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_lane();
    run_cycle(1, 1, 0, 0, 1);
    n_cmp++;
    if (bus.hit_R20S[0] !== 24'h000400) begin
      n_err++; $display("FAIL single_x: got %h want 000400", bus.hit_R20S[0]);
    end
    run_cycle(0, 0, 0, 0, 1);
    run_cycle(0, 0, 0, 0, 1);
  endtask

  task automatic test_dual_order();
    run_cycle(1, 10, 1, 11, 0);
    run_cycle(0, 0, 1, 12, 0);
    n_cmp++;
    if (dut.count !== 5'd3) begin
      n_err++; $display("FAIL dual_peak_count: got %0d want 3", dut.count);
    end
    run_cycle(0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0);
    drain("dual");
  endtask

  task automatic test_fill_halt();
    int id;
    id = 100;
    for (int i = 0; i < 12; i++) begin
      if (bus.halt_RnnnnL === 1'b1) begin
        run_cycle(1, id, 1, id + 1, 0);
        id += 2;
      end else begin
        run_cycle(0, 0, 0, 0, 0);
      end
    end
    n_cmp++;
    if (dut.count > 5'd16 || dut.count < 5'd15) begin
      n_err++; $display("FAIL fill_count: got %0d want 15..16", dut.count);
    end
    drain("fill");
  endtask

  task automatic test_full_pop_wrap();
    for (int i = 0; i < 8; i++) run_cycle(1, 200 + 2 * i, 1, 201 + 2 * i, 0);
    run_cycle(1, 216, 0, 0, 1);
    n_cmp++;
    if (dut.count !== 5'd16) begin
      n_err++; $display("FAIL full_pop_count: got %0d want 16", dut.count);
    end
    for (int i = 217; i < 240; i++) run_cycle(1, i, 0, 0, 1);
    drain("wrap");
  endtask

  task automatic test_overflow();
    hit_entry_t d;
    d = mk(333);
    run_cycle(1, 300, 0, 0, 0);
    for (int i = 0; i < 7; i++) run_cycle(1, 301 + 2 * i, 1, 302 + 2 * i, 0);
    n_cmp++;
    if (dut.count !== 5'd15) begin
      n_err++; $display("FAIL ovf_pre_count: got %0d want 15", dut.count);
    end
    run_cycle(1, 333, 1, 334, 0);
    n_cmp++;
    if (bus.overflow_RnnnnH !== 1'b1) begin
      n_err++; $display("FAIL ovf_flag: got %b want 1", bus.overflow_RnnnnH);
    end
    drain("ovf");
    n_cmp++;
    if (last_pop !== d) begin
      n_err++; $display("FAIL ovf_last: got %h want %h", last_pop, d);
    end
  endtask

  task automatic test_reset_mid();
    run_cycle(1, 400, 0, 0, 0);
    for (int i = 0; i < 3; i++) run_cycle(1, 401 + 2 * i, 1, 402 + 2 * i, 0);
    n_cmp++;
    if (dut.count !== 5'd7) begin
      n_err++; $display("FAIL mid_count: got %0d want 7", dut.count);
    end
    set_idle();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.hit_valid_R20H !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_valid: got %b want 0", bus.hit_valid_R20H);
    end
    n_cmp++;
    if (bus.halt_RnnnnL !== 1'b1) begin
      n_err++; $display("FAIL mid_rst_halt: got %b want 1", bus.halt_RnnnnL);
    end
    exp_q.delete();
    mcount = 0;
    movf   = 1'b0;
    @(posedge clk);
    #5;
    rst = 1'b0;
    tick();
    run_cycle(1, 500, 0, 0, 1);
    n_cmp++;
    if (dut.rd_ptr !== 4'd0) begin
      n_err++; $display("FAIL mid_rd_ptr: got %0d want 0", dut.rd_ptr);
    end
    drain("mid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    set_idle();
    bus.hit_valid_R18H = 1'b0;
    bus.hit_valid_R19H = 1'b0;
    bus.hit_R18S   = '0;
    bus.color_R18U = '0;
    bus.hit_R19S   = '0;
    bus.color_R19U = '0;
    last_pop = '0;
    test_reset();
    test_single_lane();
    test_dual_order();
    test_fill_halt();
    test_full_pop_wrap();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
